// File: rtl/ftdi_fifo_responder_pkg.sv
// Shared types and default sizing for the FTDI FIFO-mode responder.
package ftdi_pkg;

  localparam int unsigned FTDI_DEPTH_DEFAULT = 16;
  localparam int unsigned FTDI_INACT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READING = 2'd1,
    ST_WRITING = 2'd2,
    ST_RECOVER = 2'd3
  } ftdi_state_e;

endpackage

// File: rtl/ftdi_fifo_responder_if.sv
// Host-side FT245-style pin bundle: strobes and data bus in, data/flags out.
interface ftdi_fifo_responder_if;

  logic       rd_n;
  logic       wr_n;
  logic [7:0] adbus_in;
  logic [7:0] adbus_out;
  logic       adbus_oe;
  logic       rxf_n;
  logic       txe_n;

  modport master (
    output rd_n, wr_n, adbus_in,
    input  adbus_out, adbus_oe, rxf_n, txe_n
  );

  modport slave (
    input  rd_n, wr_n, adbus_in,
    output adbus_out, adbus_oe, rxf_n, txe_n
  );

endinterface

// File: rtl/ftdi_fifo_responder_byte_fifo.sv
// Synchronous show-ahead byte FIFO; the head entry is visible on rd_data
// whenever empty is low.
module ftdi_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         wr_en,
  input  logic [7:0]                   wr_data,
  input  logic                         rd_en,
  output logic [7:0]                   rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   usedw,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] usedw_q, usedw_d;
  logic          do_wr, do_rd;

  always_comb begin
    full     = (usedw_q == CW'(DEPTH));
    empty    = (usedw_q == '0);
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    usedw_d  = usedw_q;
    if (do_wr && !do_rd) begin
      usedw_d = usedw_q + CW'(1);
    end else if (!do_wr && do_rd) begin
      usedw_d = usedw_q - CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign usedw   = usedw_q;

endmodule

// File: rtl/ftdi_fifo_responder.sv
// FT245-style FIFO responder: the host reads bytes queued locally on src_*
// and writes bytes delivered locally on snk_*, through two byte buffers.
module ftdi_fifo_responder
  import ftdi_pkg::*;
#(
  parameter int unsigned DEPTH        = FTDI_DEPTH_DEFAULT,
  parameter int unsigned INACT_CYCLES = FTDI_INACT_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset_n,
  ftdi_fifo_responder_if.slave       host,
  input  logic [7:0]                 src_data,
  input  logic                       src_valid,
  output logic                       src_ready,
  output logic [7:0]                 snk_data,
  output logic                       snk_valid,
  input  logic                       snk_ready,
  output logic [$clog2(DEPTH+1)-1:0] rx_count,
  output logic [$clog2(DEPTH+1)-1:0] tx_count,
  output logic                       proto_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned RW = $clog2(INACT_CYCLES + 1);

  ftdi_state_e   state_q, state_d;
  logic [RW-1:0] rcv_cnt_q, rcv_cnt_d;

  logic          rd_meta_q, rd_s_q, rd_prev_q;
  logic          wr_meta_q, wr_s_q, wr_prev_q;
  logic [7:0]    ad_meta_q, ad_s_q;
  logic          rd_fall, wr_fall;

  logic          rxf_q, rxf_d;
  logic          txe_q, txe_d;
  logic          src_ready_q, src_ready_d;
  logic          proto_err_q, proto_err_d;
  logic          awake_q, awake_d;
  logic [7:0]    adbus_out_q, adbus_out_d;

  logic          rx_push, rx_pop, tx_push, tx_pop;
  logic [7:0]    rx_head, tx_head;
  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic [CW-1:0] rx_used, tx_used;

  ftdi_byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (rx_push),
    .wr_data (src_data),
    .rd_en   (rx_pop),
    .rd_data (rx_head),
    .usedw   (rx_used),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  ftdi_byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (tx_push),
    .wr_data (ad_s_q),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .usedw   (tx_used),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  // State register plus the synchronizers and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rcv_cnt_q   <= '0;
      rd_meta_q   <= 1'b1;
      rd_s_q      <= 1'b1;
      rd_prev_q   <= 1'b1;
      wr_meta_q   <= 1'b1;
      wr_s_q      <= 1'b1;
      wr_prev_q   <= 1'b1;
      ad_meta_q   <= '0;
      ad_s_q      <= '0;
      rxf_q       <= 1'b1;
      txe_q       <= 1'b1;
      src_ready_q <= 1'b0;
      proto_err_q <= 1'b0;
      awake_q     <= 1'b0;
      adbus_out_q <= '0;
    end else begin
      state_q     <= state_d;
      rcv_cnt_q   <= rcv_cnt_d;
      rd_meta_q   <= host.rd_n;
      rd_s_q      <= rd_meta_q;
      rd_prev_q   <= rd_s_q;
      wr_meta_q   <= host.wr_n;
      wr_s_q      <= wr_meta_q;
      wr_prev_q   <= wr_s_q;
      ad_meta_q   <= host.adbus_in;
      ad_s_q      <= ad_meta_q;
      rxf_q       <= rxf_d;
      txe_q       <= txe_d;
      src_ready_q <= src_ready_d;
      proto_err_q <= proto_err_d;
      awake_q     <= awake_d;
      adbus_out_q <= adbus_out_d;
    end
  end

  assign rd_fall = rd_prev_q && !rd_s_q;
  assign wr_fall = wr_prev_q && !wr_s_q;

  // Next-state logic. A write that falls while rd_s is low is a collision
  // and is never captured; the read side wins.
  always_comb begin
    state_d   = state_q;
    rcv_cnt_d = rcv_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_fall && !rxf_q) begin
          state_d = ST_READING;
        end else if (wr_fall && !txe_q && rd_s_q) begin
          state_d = ST_WRITING;
        end
      end
      ST_READING: begin
        if (rd_s_q) begin
          state_d   = ST_RECOVER;
          rcv_cnt_d = RW'(INACT_CYCLES - 1);
        end
      end
      ST_WRITING: begin
        if (wr_s_q) begin
          state_d   = ST_RECOVER;
          rcv_cnt_d = RW'(INACT_CYCLES - 1);
        end
      end
      ST_RECOVER: begin
        if (rcv_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          rcv_cnt_d = rcv_cnt_q - RW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    rx_push     = src_valid && src_ready_q;
    rx_pop      = (state_q == ST_READING) && (state_d == ST_RECOVER);
    tx_push     = (state_q == ST_IDLE) && (state_d == ST_WRITING);
    tx_pop      = !tx_empty && snk_ready;
    awake_d     = 1'b1;
    proto_err_d = proto_err_q || (!rd_s_q && !wr_s_q);
    src_ready_d = rx_pop ? 1'b1
                : !(rx_full || (rx_push && (rx_used == CW'(DEPTH - 1))));
    // Flags use the pre-update buffer state so a freshly pushed byte is
    // already in memory and loaded into adbus_out before rxf_n falls.
    rxf_d = !(((state_d == ST_IDLE) || (state_d == ST_READING)) && !rx_empty);
    txe_d = !(awake_q && (state_d == ST_IDLE) && !tx_full);
    adbus_out_d = (rxf_q && !rx_empty) ? rx_head : adbus_out_q;
  end

  assign host.adbus_oe  = ~host.rd_n;
  assign host.adbus_out = adbus_out_q;
  assign host.rxf_n     = rxf_q;
  assign host.txe_n     = txe_q;
  assign src_ready      = src_ready_q;
  assign snk_data       = tx_head;
  assign snk_valid      = !tx_empty;
  assign rx_count       = rx_used;
  assign tx_count       = tx_used;
  assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_ftdi_fifo_responder.sv
// Self-checking bench for ftdi_fifo_responder using queue-based models of
// the two byte streams and host-pin transfer tasks.
module tb_ftdi_fifo_responder;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned INACT = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset_n;
  logic [7:0]    src_data;
  logic          src_valid;
  logic          src_ready;
  logic [7:0]    snk_data;
  logic          snk_valid;
  logic          snk_ready;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;
  logic          proto_err;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [7:0] rx_model[$];
  logic [7:0] tx_model[$];

  ftdi_fifo_responder_if hif();

  ftdi_fifo_responder #(.DEPTH(DEPTH), .INACT_CYCLES(INACT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .host      (hif),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .snk_data  (snk_data),
    .snk_valid (snk_valid),
    .snk_ready (snk_ready),
    .rx_count  (rx_count),
    .tx_count  (tx_count),
    .proto_err (proto_err)
  );

  always #5 clock = ~clock;

  // Local producer: n bytes (random or fixed), one per cycle while src_ready.
  task automatic push_bytes(input int unsigned n, input bit rnd, input logic [7:0] b);
    int unsigned sent = 0;
    for (int i = 0; i < 400 && sent < n; i++) begin
      @(negedge clock);
      if (src_ready) begin
        src_valid = 1'b1;
        src_data  = rnd ? 8'($urandom) : b;
        rx_model.push_back(src_data);
        sent++;
      end else begin
        src_valid = 1'b0;
      end
    end
    @(negedge clock);
    src_valid = 1'b0;
    vectors++;
    if (sent != n) begin
      miscompares++;
      $display("FAIL push_timeout sent=%0d required=%0d", sent, n);
    end
  endtask

  // Local consumer: pops everything the model expects, checking order.
  task automatic drain_all();
    logic [7:0] exp;
    @(negedge clock);
    for (int i = 0; i < 200 && tx_model.size() > 0; i++) begin
      if (snk_valid) begin
        exp = tx_model.pop_front();
        vectors++;
        if (snk_data !== exp) begin
          miscompares++;
          $display("FAIL snk_data got=%h required=%h", snk_data, exp);
        end
        snk_ready = 1'b1;
      end else begin
        snk_ready = 1'b0;
      end
      @(negedge clock);
    end
    snk_ready = 1'b0;
    vectors++;
    if (tx_model.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout left=%0d required=0", tx_model.size());
    end
  endtask

  // Host read transfer: wait for rxf_n, strobe rd_n, check data and recovery.
  task automatic host_read(input int unsigned low_cycles);
    logic [7:0]  exp;
    bit          ok = 1'b0;
    int unsigned n  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (hif.rxf_n == 1'b0) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rd_wait_rxf rxf_n=%b required=0", hif.rxf_n);
      return;
    end
    exp = rx_model.pop_front();
    hif.rd_n = 1'b0;
    for (int i = 0; i < low_cycles; i++) begin
      @(negedge clock);
      vectors++;
      if (hif.adbus_oe !== 1'b1 || hif.adbus_out !== exp) begin
        miscompares++;
        $display("FAIL rd_data oe=%b data=%h required oe=1 data=%h",
                 hif.adbus_oe, hif.adbus_out, exp);
      end
    end
    hif.rd_n = 1'b1;
    for (int i = 0; i < 10 && n == 0; i++) begin
      @(negedge clock);
      if (hif.rxf_n === 1'b1) n = 1;
    end
    for (int i = 1; i < INACT && n == i; i++) begin
      @(negedge clock);
      if (hif.rxf_n === 1'b1) n++;
    end
    vectors++;
    if (n != INACT) begin
      miscompares++;
      $display("FAIL rd_recover rxf_high_cycles=%0d required=%0d", n, INACT);
    end
  endtask

  // Host write transfer: wait for txe_n, strobe wr_n, check recovery.
  task automatic host_write(input logic [7:0] b, input int unsigned low_cycles);
    bit          ok = 1'b0;
    int unsigned n  = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (hif.txe_n == 1'b0) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wr_wait_txe txe_n=%b required=0", hif.txe_n);
      return;
    end
    hif.adbus_in = b;
    hif.wr_n     = 1'b0;
    tx_model.push_back(b);
    repeat (low_cycles) @(negedge clock);
    hif.wr_n = 1'b1;
    for (int i = 0; i < 10 && n == 0; i++) begin
      @(negedge clock);
      if (hif.txe_n === 1'b1) n = 1;
    end
    for (int i = 1; i < INACT && n == i; i++) begin
      @(negedge clock);
      if (hif.txe_n === 1'b1) n++;
    end
    vectors++;
    if (n != INACT) begin
      miscompares++;
      $display("FAIL wr_recover txe_high_cycles=%0d required=%0d", n, INACT);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if (hif.rxf_n !== 1'b1 || hif.txe_n !== 1'b1 || src_ready !== 1'b0 ||
        snk_valid !== 1'b0 || hif.adbus_out !== 8'h00 || rx_count !== '0 ||
        tx_count !== '0 || proto_err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s rxf=%b txe=%b srdy=%b svld=%b ad=%h rxc=%0d txc=%0d perr=%b required 1 1 0 0 00 0 0 0",
               tag, hif.rxf_n, hif.txe_n, src_ready, snk_valid, hif.adbus_out,
               rx_count, tx_count, proto_err);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset_values");
    reset_n = 1'b1;
    @(negedge clock);
    vectors++;
    if (src_ready !== 1'b1 || hif.txe_n !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_edge1 src_ready=%b txe_n=%b required 1 1", src_ready, hif.txe_n);
    end
    @(negedge clock);
    vectors++;
    if (hif.txe_n !== 1'b0 || hif.rxf_n !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_edge2 txe_n=%b rxf_n=%b required 0 1", hif.txe_n, hif.rxf_n);
    end
  endtask

  task automatic test_host_read();
    push_bytes(1, 1'b0, 8'hA5);
    vectors++;
    if (rx_count !== CW'(1)) begin
      miscompares++;
      $display("FAIL rd_count_pre got=%0d required=1", rx_count);
    end
    host_read(6);
    vectors++;
    if (rx_count !== '0 || hif.rxf_n !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_count_post rx_count=%0d rxf_n=%b required 0 1", rx_count, hif.rxf_n);
    end
  endtask

  task automatic test_host_write();
    snk_ready = 1'b0;
    host_write(8'h3C, 4);
    vectors++;
    if (snk_valid !== 1'b1 || snk_data !== 8'h3C || tx_count !== CW'(1)) begin
      miscompares++;
      $display("FAIL wr_capture valid=%b data=%h count=%0d required 1 3c 1",
               snk_valid, snk_data, tx_count);
    end
    drain_all();
    vectors++;
    if (tx_count !== '0 || snk_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_drained count=%0d valid=%b required 0 0", tx_count, snk_valid);
    end
  endtask

  task automatic test_full_empty();
    snk_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) host_write(8'($urandom), 4);
    repeat (INACT + 4) @(negedge clock);
    vectors++;
    if (tx_count !== CW'(DEPTH) || hif.txe_n !== 1'b1) begin
      miscompares++;
      $display("FAIL full_flag count=%0d txe_n=%b required %0d 1", tx_count, hif.txe_n, DEPTH);
    end
    hif.adbus_in = 8'hEE;
    hif.wr_n     = 1'b0;
    repeat (4) @(negedge clock);
    hif.wr_n = 1'b1;
    repeat (10) @(negedge clock);
    vectors++;
    if (tx_count !== CW'(DEPTH)) begin
      miscompares++;
      $display("FAIL full_write_ignored count=%0d required=%0d", tx_count, DEPTH);
    end
    drain_all();
    repeat (3) @(negedge clock);
    hif.rd_n = 1'b0;
    repeat (6) @(negedge clock);
    vectors++;
    if (hif.rxf_n !== 1'b1 || hif.txe_n !== 1'b0 || rx_count !== '0) begin
      miscompares++;
      $display("FAIL empty_read_ignored rxf_n=%b txe_n=%b rx_count=%0d required 1 0 0",
               hif.rxf_n, hif.txe_n, rx_count);
    end
    hif.rd_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_collision();
    bit ok = 1'b0;
    push_bytes(1, 1'b0, 8'h5A);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (hif.rxf_n == 1'b0) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL col_wait_rxf rxf_n=%b required=0", hif.rxf_n);
    end
    hif.adbus_in = 8'h77;
    hif.rd_n     = 1'b0;
    hif.wr_n     = 1'b0;
    repeat (5) @(negedge clock);
    vectors++;
    if (hif.adbus_out !== 8'h5A) begin
      miscompares++;
      $display("FAIL col_read_data got=%h required=5a", hif.adbus_out);
    end
    hif.rd_n = 1'b1;
    hif.wr_n = 1'b1;
    void'(rx_model.pop_front());
    repeat (INACT + 8) @(negedge clock);
    vectors++;
    if (proto_err !== 1'b1 || tx_count !== '0 || rx_count !== '0) begin
      miscompares++;
      $display("FAIL collision perr=%b tx_count=%0d rx_count=%0d required 1 0 0",
               proto_err, tx_count, rx_count);
    end
    host_write(8'h11, 3);
    drain_all();
    vectors++;
    if (proto_err !== 1'b1) begin
      miscompares++;
      $display("FAIL perr_sticky got=%b required=1", proto_err);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok = 1'b0;
    push_bytes(3, 1'b1, 8'h00);
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (hif.rxf_n == 1'b0) begin ok = 1'b1; break; end
    end
    hif.rd_n = 1'b0;
    repeat (4) @(negedge clock);
    vectors++;
    if (!ok || rx_count !== CW'(3)) begin
      miscompares++;
      $display("FAIL mid_read_setup rxf_seen=%b rx_count=%0d required 1 3", ok, rx_count);
    end
    reset_n = 1'b0;
    #1;
    check_idle_outputs("mid_read_reset");
    hif.rd_n = 1'b1;
    rx_model.delete();
    tx_model.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if (rx_count !== '0 || hif.rxf_n !== 1'b1 || src_ready !== 1'b1 || hif.txe_n !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset rx_count=%0d rxf_n=%b src_ready=%b txe_n=%b required 0 1 1 0",
               rx_count, hif.rxf_n, src_ready, hif.txe_n);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    push_bytes(2, 1'b1, 8'h00);
    fork
      host_read(5);
      push_bytes(12, 1'b1, 8'h00);
    join
    vectors++;
    if (rx_count !== CW'(rx_model.size())) begin
      miscompares++;
      $display("FAIL push_pop_overlap rx_count=%0d required=%0d", rx_count, rx_model.size());
    end
    for (int i = 0; i < 2 * DEPTH && rx_model.size() > 0; i++) host_read(3);

    snk_ready = 1'b0;
    for (int i = 0; i < 8; i++) host_write(8'($urandom), 3);
    @(negedge clock);
    fork
      host_write(8'($urandom), 4);
      begin
        for (int i = 0; i < 40; i++) begin
          if (snk_valid && tx_model.size() > 0) begin
            exp = tx_model.pop_front();
            vectors++;
            if (snk_data !== exp) begin
              miscompares++;
              $display("FAIL overlap_snk_data got=%h required=%h", snk_data, exp);
            end
            snk_ready = 1'b1;
          end else begin
            snk_ready = 1'b0;
          end
          @(negedge clock);
        end
        snk_ready = 1'b0;
      end
    join
    vectors++;
    if (tx_count !== '0 || tx_model.size() != 0) begin
      miscompares++;
      $display("FAIL capture_pop_overlap tx_count=%0d left=%0d required 0 0",
               tx_count, tx_model.size());
    end
  endtask

  task automatic test_random();
    int unsigned op;
    for (int k = 0; k < 200; k++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: if (rx_model.size() < DEPTH)
             push_bytes($urandom_range(1, DEPTH - rx_model.size()), 1'b1, 8'h00);
        1: if (rx_model.size() > 0) host_read($urandom_range(3, 6));
        2: if (tx_model.size() < DEPTH) host_write(8'($urandom), $urandom_range(3, 6));
        default: drain_all();
      endcase
      vectors++;
      if (rx_count !== CW'(rx_model.size()) || tx_count !== CW'(tx_model.size())) begin
        miscompares++;
        $display("FAIL random_counts op=%0d rx=%0d tx=%0d required %0d %0d",
                 op, rx_count, tx_count, rx_model.size(), tx_model.size());
      end
    end
    for (int i = 0; i < 2 * DEPTH && rx_model.size() > 0; i++) host_read(4);
    drain_all();
    vectors++;
    if (rx_count !== '0 || tx_count !== '0) begin
      miscompares++;
      $display("FAIL random_final rx=%0d tx=%0d required 0 0", rx_count, tx_count);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    hif.rd_n     = 1'b1;
    hif.wr_n     = 1'b1;
    hif.adbus_in = 8'h00;
    src_valid    = 1'b0;
    src_data     = 8'h00;
    snk_ready    = 1'b0;
    test_reset();
    test_host_read();
    test_host_write();
    test_full_empty();
    test_collision();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ftdi_fifo_responder.md
FTDI_FIFO_RESPONDER -- requirements
Module: ftdi_fifo_responder

Interface
REQ-001 Parameter DEPTH, default 16, entries in each internal byte buffer; power of two, at least 4.
REQ-002 Parameter INACT_CYCLES, default 4, minimum clock cycles rxf_n/txe_n stay high after a completed transfer.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  sole clock, rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 rd_n  input  1  host read strobe, active low, asynchronous to clock.
REQ-007 wr_n  input  1  host write strobe, active low, asynchronous to clock.
REQ-008 adbus_in  input  8  host-driven data bus, asynchronous to clock.
REQ-009 adbus_out  output  8  byte presented to host on reads.
REQ-010 adbus_oe  output  1  pad drive enable for adbus_out.
REQ-011 rxf_n  output  1  low = a byte is available for the host to read.
REQ-012 txe_n  output  1  low = room to accept a host write.
REQ-013 src_data  input  8 / src_valid  input  1 / src_ready  output  1  local bytes queued for host reads.
REQ-014 snk_data  output  8 / snk_valid  output  1 / snk_ready  input  1  bytes written by the host.
REQ-015 rx_count, tx_count  output  $clog2(DEPTH+1)  occupancy of the read buffer and the write buffer.
REQ-016 proto_err  output  1  sticky flag: rd_n and wr_n seen low together.

Function
REQ-017 rd_n, wr_n and adbus_in each pass through a 2-flop synchronizer; all control decisions use only the synchronized copies (rd_s, wr_s, ad_s).
REQ-018 adbus_oe = ~rd_n (raw input, combinational); adbus_out = registered head of the read buffer, held stable whenever rxf_n is low.
REQ-019 Local push: a read-buffer write occurs on src_valid && src_ready; src_ready = !read_buffer_full.
REQ-020 Local pop: snk_data/snk_valid show the write-buffer head; pop on snk_valid && snk_ready.
REQ-021 FSM states: IDLE, READING, WRITING, RECOVER.
REQ-022 IDLE -> READING when rd_s falls while rxf_n is low; IDLE -> WRITING when wr_s falls while txe_n is low.
REQ-023 READING -> RECOVER when rd_s rises; pop the read buffer in that cycle.
REQ-024 WRITING: capture ad_s into the write buffer in the first cycle wr_s is seen low (the IDLE->WRITING cycle).
REQ-025 WRITING -> RECOVER when wr_s rises.
REQ-026 RECOVER: hold for INACT_CYCLES cycles, using a down-counter, then go to IDLE.
REQ-027 rxf_n is low only in IDLE or READING, and only with the read buffer non-empty.
REQ-028 txe_n is low only in IDLE, and only with the write buffer not full.
REQ-029 Both rxf_n and txe_n are registered outputs.
REQ-030 Strobe while its flag is high (read when empty, write when full): ignore it; no buffer change, no state change.
REQ-031 rd_s and wr_s both low in the same cycle: set proto_err; read takes precedence; no write capture.
REQ-032 Local push and host pop in the same cycle: both take effect; rx_count is unchanged.
REQ-033 Host capture and local pop in the same cycle: both take effect; tx_count is unchanged.
REQ-034 Buffer pointers wrap modulo DEPTH; counts saturate at neither end, and overflow is impossible by REQ-019/REQ-028.

Reset
REQ-035 reset_n low at any time, including mid-transfer: state IDLE, both buffers empty, RECOVER counter 0, proto_err 0, rxf_n=1, txe_n=1, src_ready=0, snk_valid=0, adbus_out=8'h00, counts 0; synchronizer flops to 1 (strobes) / 0 (data).
REQ-036 After reset_n rises: src_ready=1 and txe_n=0 on the first and second clock edges respectively.

Structure
REQ-037 Package ftdi_pkg holds the responder state enum and the INACT_CYCLES/DEPTH default constants.
REQ-038 One sub-module, ftdi_byte_fifo: a synchronous show-ahead FIFO with usedw/full/empty outputs, instantiated twice (read and write buffers).

Verification
REQ-039 Host read: push 8'hA5 locally; after rxf_n falls, pulse rd_n low for 6 cycles -> adbus_out=8'hA5 while adbus_oe=1; rxf_n high ≥INACT_CYCLES after rd_n rises; rx_count returns to 0.
REQ-040 Host write: hold adbus_in=8'h3C and pulse wr_n low 4 cycles -> snk_valid=1, snk_data=8'h3C; txe_n high until INACT_CYCLES after wr_n rises.
REQ-041 Full and empty: with snk_ready=0, perform 16 writes -> txe_n stays high, and a 17th wr_n pulse leaves tx_count=16. rd_n pulsed while the read buffer is empty -> no state change.
REQ-042 Collision: drive rd_n and wr_n low together -> proto_err=1 (sticky); read completes; tx_count unchanged.
REQ-043 Reset mid-read: assert reset_n low while rd_n is low and rx_count=3 -> all outputs at reset values; rx_count=0 after release.
REQ-044 Loopback stress: pair with FTDI_Interface, 1024 random bytes in each direction -> byte-exact, in-order delivery at both ends.
